// File: rtl/cpu_pkg.sv
// Shared definitions for the control unit: opcode values (identical to the
// ALU operation encodings), FSM state encoding, opcode classes and the
// instruction-byte layout.
package cpu_pkg;

  localparam int unsigned PC_W  = 8;
  localparam int unsigned OPC_W = 4;

  localparam logic [OPC_W-1:0] OP_NOP  = 4'b0000;
  localparam logic [OPC_W-1:0] OP_ADD  = 4'b0001;
  localparam logic [OPC_W-1:0] OP_SUB  = 4'b0010;
  localparam logic [OPC_W-1:0] OP_AND  = 4'b0011;
  localparam logic [OPC_W-1:0] OP_OR   = 4'b0100;
  localparam logic [OPC_W-1:0] OP_NOT  = 4'b0101;
  localparam logic [OPC_W-1:0] OP_SLT  = 4'b0111;
  localparam logic [OPC_W-1:0] OP_JZ   = 4'b1000;
  localparam logic [OPC_W-1:0] OP_HALT = 4'b1111;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_DECODE  = 2'd1,
    ST_EXECUTE = 2'd2,
    ST_HALT    = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_ALU,
    CLS_JZ,
    CLS_HALT,
    CLS_ILLEGAL
  } op_class_e;

  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [1:0]       rd;
    logic [1:0]       rs;
  } instr_t;

  // Branch target: already-incremented pc plus the sign-extended 4-bit
  // {rd,rs} field; the 8-bit sum wraps naturally.
  function automatic logic [PC_W-1:0] jz_target(input logic [PC_W-1:0] pc,
                                                 input logic [3:0]      off);
    return pc + {{(PC_W-4){off[3]}}, off};
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Purely combinational opcode classifier: maps a 4-bit opcode onto the
// class the control FSM acts on.
module instr_decode
  import cpu_pkg::*;
(
  input  logic [OPC_W-1:0] opcode_i,
  output op_class_e        op_class_o
);

  // Classify the opcode; anything not listed is undefined.
  always_comb begin
    // NOTE: a default assigned before the case keeps every path driven, so
    // no latch is inferred when a new opcode is left out of the list.
    op_class_o = CLS_ILLEGAL;
    case (opcode_i)
      OP_NOP:                                   op_class_o = CLS_NOP;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT,
      OP_SLT:                                   op_class_o = CLS_ALU;
      OP_JZ:                                    op_class_o = CLS_JZ;
      OP_HALT:                                  op_class_o = CLS_HALT;
      default:                                  op_class_o = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control unit: FETCH -> DECODE -> EXECUTE, with a terminal
// HALT state. Owns the pc, instruction register and zero flag; all strobes
// are decoded from state so reset removes them immediately.
module control_unit
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  output logic             instr_req,
  output logic [PC_W-1:0]  pc,
  input  logic             instr_valid,
  input  logic [7:0]       instr_data,
  output logic [OPC_W-1:0] alu_op,
  input  logic             alu_zero,
  output logic [1:0]       rd_sel,
  output logic [1:0]       rs_sel,
  output logic             reg_we,
  output logic             zero_flag,
  output logic             illegal,
  output logic             halted
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  instr_t          ir_q, ir_d;
  logic            zero_q, zero_d;
  op_class_e       op_class;

  instr_decode u_decode (
    .opcode_i   (ir_q.opcode),
    .op_class_o (op_class)
  );

  // State, pc, IR and Z flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      zero_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register update from the
      // values of the previous cycle, independent of statement order.
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      zero_q  <= zero_d;
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    zero_d    = zero_q;
    instr_req = 1'b0;
    alu_op    = OP_NOP;
    reg_we    = 1'b0;
    illegal   = 1'b0;
    halted    = 1'b0;

    case (state_q)
      ST_FETCH: begin
        instr_req = 1'b1;
        if (instr_valid) begin
          ir_d    = instr_t'(instr_data);
          pc_d    = pc_q + 8'd1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_d = (op_class == CLS_HALT) ? ST_HALT : ST_EXECUTE;
      end
      ST_EXECUTE: begin
        state_d = ST_FETCH;
        case (op_class)
          CLS_ALU: begin
            alu_op = ir_q.opcode;
            reg_we = 1'b1;
            zero_d = alu_zero;
          end
          CLS_JZ: begin
            if (zero_q) pc_d = jz_target(pc_q, {ir_q.rd, ir_q.rs});
          end
          CLS_ILLEGAL: illegal = 1'b1;
          default: ;
        endcase
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  assign pc        = pc_q;
  assign rd_sel    = ir_q.rd;
  assign rs_sel    = ir_q.rs;
  assign zero_flag = zero_q;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit. An instruction-level model is
// compared against the DUT on every falling edge; directed sequences add
// hand-computed literal expectations.
module tb_control_unit;

  logic       clk, rst_n;
  logic       instr_req, instr_valid, alu_zero;
  logic       reg_we, zero_flag, illegal, halted;
  logic [7:0] pc, instr_data;
  logic [3:0] alu_op;
  logic [1:0] rd_sel, rs_sel;

  int n_checks = 0;
  int n_pass   = 0;
  int we_cnt   = 0;
  int ill_cnt  = 0;

  // Model state: phase 0=fetch 1=decode 2=execute 3=halt.
  int         m_phase, m_pc, opc, off, we_base, ill_base;
  logic       m_z;
  logic [7:0] m_ir;
  bit         m_alu, m_ill, in_exec;

  control_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_req   (instr_req),
    .pc          (pc),
    .instr_valid (instr_valid),
    .instr_data  (instr_data),
    .alu_op      (alu_op),
    .alu_zero    (alu_zero),
    .rd_sel      (rd_sel),
    .rs_sel      (rs_sel),
    .reg_we      (reg_we),
    .zero_flag   (zero_flag),
    .illegal     (illegal),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Per-cycle comparison against the instruction-level model.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_phase = 0; m_pc = 0; m_z = 1'b0; m_ir = 8'h00;
    end
    opc     = int'(m_ir[7:4]);
    m_alu   = (opc inside {1, 2, 3, 4, 5, 7});
    m_ill   = (opc == 6) || (opc >= 9 && opc <= 14);
    in_exec = (m_phase == 2);

    check("instr_req", 32'(instr_req), 32'(m_phase == 0));
    check("pc",        32'(pc),        32'(m_pc));
    check("alu_op",    32'(alu_op),    32'((in_exec && m_alu) ? opc : 0));
    check("reg_we",    32'(reg_we),    32'(in_exec && m_alu));
    check("illegal",   32'(illegal),   32'(in_exec && m_ill));
    check("halted",    32'(halted),    32'(m_phase == 3));
    check("zero_flag", 32'(zero_flag), 32'(m_z));
    if (m_phase == 1 || m_phase == 2) begin
      check("rd_sel", 32'(rd_sel), 32'(m_ir[3:2]));
      check("rs_sel", 32'(rs_sel), 32'(m_ir[1:0]));
    end
    if (reg_we === 1'b1)  we_cnt++;
    if (illegal === 1'b1) ill_cnt++;

    if (rst_n) begin
      case (m_phase)
        0: if (instr_valid) begin
             m_ir = instr_data; m_pc = (m_pc + 1) % 256; m_phase = 1;
           end
        1: m_phase = (opc == 15) ? 3 : 2;
        2: begin
             if (m_alu) m_z = alu_zero;
             if (opc == 8 && m_z) begin
               off = int'(m_ir[3:0]);
               if (off > 7) off = off - 16;
               m_pc = (m_pc + off + 256) % 256;
             end
             m_phase = 0;
           end
        default: m_phase = 3;
      endcase
    end
  end

  // Runs one instruction from FETCH; starts and ends at posedge+1.
  // With noise set, instr_valid is held high with a HALT byte while the
  // fetch request is low.
  task automatic do_instr(input logic [7:0] data, input logic az,
                          input bit noise);
    alu_zero    = az;
    instr_valid = 1'b1;
    instr_data  = data;
    @(posedge clk); #1;
    instr_valid = noise;
    instr_data  = 8'hF5;
    @(posedge clk); #1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
  endtask

  task automatic reset_pulse();
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr_data = 8'h00; alu_zero = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_req", 32'(instr_req), 32'd1);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_zero", 32'(zero_flag), 32'd0);
    check("rst_rd", 32'(rd_sel), 32'd0);

    // ADD r1,r2: cycle-by-cycle expectations.
    instr_valid = 1'b1; instr_data = 8'h16;
    @(negedge clk);
    check("add_c1_pc", 32'(pc), 32'd0);
    @(posedge clk); #1 instr_valid = 1'b0;
    @(negedge clk);
    check("add_c2_pc", 32'(pc), 32'd1);
    check("add_c2_we", 32'(reg_we), 32'd0);
    @(negedge clk);
    check("add_c3_op", 32'(alu_op), 32'h1);
    check("add_c3_we", 32'(reg_we), 32'd1);
    check("add_c3_rd", 32'(rd_sel), 32'd1);
    check("add_c3_rs", 32'(rs_sel), 32'd2);
    @(negedge clk);
    check("add_c4_we", 32'(reg_we), 32'd0);
    check("add_c4_req", 32'(instr_req), 32'd1);
    @(posedge clk); #1;

    // SUB sets Z, JZ -2 from pc 1 lands on 0.
    reset_pulse();
    do_instr(8'h21, 1'b1, 1'b0);
    do_instr(8'h8E, 1'b0, 1'b0);
    check("jz_taken_pc", 32'(pc), 32'd0);
    check("jz_taken_z", 32'(zero_flag), 32'd1);
    // SUB clears Z, JZ falls through to 2.
    do_instr(8'h21, 1'b0, 1'b0);
    do_instr(8'h8E, 1'b1, 1'b0);
    check("jz_not_pc", 32'(pc), 32'd2);
    check("jz_not_z", 32'(zero_flag), 32'd0);

    // Four idle fetch cycles.
    we_base = we_cnt;
    instr_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("idle_pc", 32'(pc), 32'd2);
    check("idle_req", 32'(instr_req), 32'd1);
    check("idle_we", 32'(we_cnt - we_base), 32'd0);

    // Reach pc 255 via JZ -5 from pc 3, then NOP wraps to 0.
    do_instr(8'h21, 1'b1, 1'b1);
    do_instr(8'h8B, 1'b0, 1'b1);
    check("jz_to_255", 32'(pc), 32'd255);
    do_instr(8'h00, 1'b0, 1'b1);
    check("wrap_pc", 32'(pc), 32'd0);
    check("wrap_z", 32'(zero_flag), 32'd1);

    // Other ALU ops and a forward branch of +7.
    do_instr(8'h3B, 1'b0, 1'b0);
    do_instr(8'h87, 1'b1, 1'b0);
    check("jz_fwd_not", 32'(pc), 32'd2);
    do_instr(8'h4E, 1'b1, 1'b0);
    do_instr(8'h87, 1'b0, 1'b1);
    check("jz_fwd_taken", 32'(pc), 32'd11);
    do_instr(8'h59, 1'b0, 1'b0);
    do_instr(8'h72, 1'b1, 1'b0);
    check("slt_z", 32'(zero_flag), 32'd1);

    // Undefined opcodes.
    ill_base = ill_cnt; we_base = we_cnt;
    do_instr(8'h65, 1'b0, 1'b0);
    check("ill_pulses", 32'(ill_cnt - ill_base), 32'd1);
    check("ill_we", 32'(we_cnt - we_base), 32'd0);
    for (int op = 9; op <= 14; op++) do_instr({4'(op), 4'h3}, 1'b0, 1'b0);
    check("ill_z_kept", 32'(zero_flag), 32'd1);
    check("ill_pc", 32'(pc), 32'd20);

    // HALT holds until reset, ignoring instr_valid.
    do_instr(8'hF0, 1'b0, 1'b1);
    instr_valid = 1'b1; instr_data = 8'h16;
    repeat (4) begin @(posedge clk); #1; end
    check("halt_flag", 32'(halted), 32'd1);
    check("halt_req", 32'(instr_req), 32'd0);
    check("halt_pc", 32'(pc), 32'd21);
    instr_valid = 1'b0;
    reset_pulse();
    check("unhalt_pc", 32'(pc), 32'd0);
    check("unhalt_flag", 32'(halted), 32'd0);
    check("unhalt_req", 32'(instr_req), 32'd1);

    // Reset during ADD execute drops the write strobe at once.
    instr_valid = 1'b1; instr_data = 8'h16; alu_zero = 1'b1;
    @(posedge clk); #1 instr_valid = 1'b0;
    @(posedge clk); #1;
    check("exec_we", 32'(reg_we), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_we", 32'(reg_we), 32'd0);
    check("abort_op", 32'(alu_op), 32'd0);
    check("abort_pc", 32'(pc), 32'd0);
    check("abort_rd", 32'(rd_sel), 32'd0);
    check("abort_z", 32'(zero_flag), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 clk  input  1  single rising-edge clock for all state.
REQ-002 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 instr_req  output  1  fetch request to instruction memory, held high until accepted.
REQ-004 pc  output  8  current fetch address.
REQ-005 instr_valid  input  1  instruction memory has placed instr_data for the address on pc; sampled only while instr_req=1.
REQ-006 instr_data  input  8  instruction byte: [7:4] opcode, [3:2] rd, [1:0] rs.
REQ-007 alu_op  output  4  operation code to the ALU; 4'b0000 when not executing.
REQ-008 alu_zero  input  1  ALU zero output for the operation currently on alu_op.
REQ-009 rd_sel  output  2  destination/A-operand register index.
REQ-010 rs_sel  output  2  B-operand register index.
REQ-011 reg_we  output  1  register-file write strobe, one cycle per ALU instruction.
REQ-012 zero_flag  output  1  registered Z flag from the last ALU instruction.
REQ-013 illegal  output  1  one-cycle pulse on an undefined opcode.
REQ-014 halted  output  1  high while in HALT state.

Function
REQ-015 FSM states SHALL be FETCH, DECODE, EXECUTE, HALT; reset state FETCH.
REQ-016 FETCH: instr_req=1; when instr_valid=1 the IR SHALL latch instr_data, pc SHALL increment by 1 (8-bit wrap, 255->0), next state DECODE; otherwise remain in FETCH, pc unchanged.
REQ-017 DECODE: rd_sel/rs_sel SHALL be driven from IR[3:2]/IR[1:0] and held through EXECUTE; next state EXECUTE, or HALT if opcode 4'b1111.
REQ-018 EXECUTE: for opcodes 0001 ADD, 0010 SUB, 0011 AND, 0100 OR, 0101 NOT, 0111 SLT, alu_op SHALL equal the opcode, reg_we=1, zero_flag SHALL load alu_zero at the end of the cycle; next state FETCH.
REQ-019 Opcode 0000 NOP: alu_op=0, reg_we=0, zero_flag unchanged.
REQ-020 Opcode 1000 JZ: if zero_flag=1, pc SHALL become (incremented pc) + sign-extended {rd,rs} (range -8..+7, mod 256); else pc unchanged; reg_we=0, zero_flag unchanged.
REQ-021 Opcodes 0110, 1001-1110: illegal=1 for the EXECUTE cycle, behave as NOP.
REQ-022 HALT: instr_req=0, alu_op=0, reg_we=0, halted=1; state SHALL remain HALT until reset.
REQ-023 Outside EXECUTE, alu_op SHALL be 0 and reg_we, illegal SHALL be 0.
REQ-024 Throughput: one instruction per 3 cycles when instr_valid is high on the first FETCH cycle; each idle FETCH cycle adds one.
REQ-025 instr_valid while instr_req=0 SHALL be ignored.

Reset
REQ-026 rst_n low SHALL immediately force: state FETCH, pc=0, IR=0, zero_flag=0, alu_op=0, rd_sel=0, rs_sel=0, reg_we=0, illegal=0, halted=0, instr_req=1 once rst_n deasserts.
REQ-027 Reset asserted mid-instruction SHALL abandon it with no reg_we pulse.

Structure
REQ-028 Opcode constants (matching ALU op encodings) and FSM state encoding SHALL live in shared package cpu_pkg.
REQ-029 Opcode classification (alu/nop/jz/halt/illegal) SHALL be one combinational sub-module instr_decode; the FSM, pc, IR and flag registers stay in control_unit.

Verification
REQ-030 Reset then instr_data=8'h16 (ADD r1,r2), instr_valid=1 -> pc 0->1, EXECUTE on the 3rd cycle with alu_op=0001, rd_sel=1, rs_sel=2, reg_we=1 for one cycle.
REQ-031 SUB with alu_zero=1 in EXECUTE, then JZ 8'h8E (offset -2) at pc=1 -> zero_flag=1, pc becomes 0 after the JZ EXECUTE; repeat with alu_zero=0 -> pc stays 2.
REQ-032 instr_valid held low 4 cycles in FETCH -> pc and state unchanged, instr_req stays 1, no reg_we.
REQ-033 pc=255 fetching NOP -> pc wraps to 0; zero_flag unchanged.
REQ-034 Opcode 0110 -> illegal=1 for exactly one cycle, reg_we=0; opcode 1111 -> halted=1, instr_req=0 indefinitely until rst_n pulse returns pc=0, state FETCH.
REQ-035 rst_n asserted during EXECUTE of ADD -> reg_we drops immediately, all outputs at reset values.
